transaction_control: RTL and testbench

TRANSACTION_CONTROL -- requirements
Module: transaction_control

---
 rtl/transaction_control.sv | 192 +++++++++++++++++++
 tb/tb_transaction_control.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/transaction_control.sv
// Two-player coin ledger controller: initialises both balances and performs
// checked transfers against a single-port balance memory with 1-cycle read latency.
module transaction_control #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] INIT_BALANCE = 8'd100
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             init_memory,
  input  logic             start_transaction,
  input  logic [WIDTH-1:0] amount,
  input  logic             key,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wren,
  output logic             finished_init,
  output logic             finished_transaction,
  output logic             rejected,
  output logic [WIDTH-1:0] p1_balance,
  output logic [WIDTH-1:0] p2_balance
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT_W0   = 4'd1,
    INIT_W1   = 4'd2,
    INIT_DONE = 4'd3,
    RD_SRC    = 4'd4,
    RD_DST    = 4'd5,
    CAPTURE   = 4'd6,
    CHECK     = 4'd7,
    WR_SRC    = 4'd8,
    WR_DST    = 4'd9,
    DONE      = 4'd10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] amount_q, amount_d;
  logic             key_q, key_d;
  logic [WIDTH-1:0] src_bal_q, src_bal_d;
  logic [WIDTH-1:0] dst_bal_q, dst_bal_d;
  logic             rejected_q, rejected_d;
  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] p2_q, p2_d;

  // Sum is one bit wider so a destination overflow shows up in the top bit.
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] diff_s;
  logic             reject_s;

  assign sum_s    = {1'b0, dst_bal_q} + {1'b0, amount_q};
  assign diff_s   = src_bal_q - amount_q;
  assign reject_s = (amount_q > src_bal_q) || sum_s[WIDTH];

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      amount_q   <= '0;
      key_q      <= 1'b0;
      src_bal_q  <= '0;
      dst_bal_q  <= '0;
      rejected_q <= 1'b0;
      p1_q       <= '0;
      p2_q       <= '0;
    end else begin
      state_q    <= state_d;
      amount_q   <= amount_d;
      key_q      <= key_d;
      src_bal_q  <= src_bal_d;
      dst_bal_q  <= dst_bal_d;
      rejected_q <= rejected_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
    end
  end

  // Next-state and register update logic.
  always_comb begin
    state_d    = state_q;
    amount_d   = amount_q;
    key_d      = key_q;
    src_bal_d  = src_bal_q;
    dst_bal_d  = dst_bal_q;
    rejected_d = rejected_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    case (state_q)
      IDLE: begin
        if (init_memory) begin
          state_d = INIT_W0;
        end else if (start_transaction) begin
          state_d    = RD_SRC;
          amount_d   = amount;
          key_d      = key;
          rejected_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      INIT_W0: begin
        p1_d    = INIT_BALANCE;
        state_d = INIT_W1;
      end
      INIT_W1: begin
        p2_d    = INIT_BALANCE;
        state_d = INIT_DONE;
      end
      INIT_DONE: begin
        if (!init_memory) state_d = IDLE;
        else              state_d = INIT_DONE;
      end
      RD_SRC:  state_d = RD_DST;
      RD_DST: begin
        src_bal_d = mem_rdata;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        dst_bal_d = mem_rdata;
        state_d   = CHECK;
      end
      CHECK: begin
        if (reject_s) begin
          rejected_d = 1'b1;
          state_d    = DONE;
        end else begin
          state_d = WR_SRC;
        end
      end
      // key 0 means player1 (addr 0) is the source.
      WR_SRC: begin
        if (!key_q) p1_d = diff_s;
        else        p2_d = diff_s;
        state_d = WR_DST;
      end
      WR_DST: begin
        if (!key_q) p2_d = sum_s[WIDTH-1:0];
        else        p1_d = sum_s[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (!start_transaction) state_d = IDLE;
        else                    state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode from the registered state.
  always_comb begin
    mem_addr  = 1'b0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state_q)
      INIT_W0: begin
        mem_addr  = 1'b0;
        mem_wdata = INIT_BALANCE;
        mem_wren  = 1'b1;
      end
      INIT_W1: begin
        mem_addr  = 1'b1;
        mem_wdata = INIT_BALANCE;
        mem_wren  = 1'b1;
      end
      RD_SRC: mem_addr = key_q;
      RD_DST: mem_addr = ~key_q;
      WR_SRC: begin
        mem_addr  = key_q;
        mem_wdata = diff_s;
        mem_wren  = 1'b1;
      end
      WR_DST: begin
        mem_addr  = ~key_q;
        mem_wdata = sum_s[WIDTH-1:0];
        mem_wren  = 1'b1;
      end
      default: begin
        mem_addr  = 1'b0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
      end
    endcase
  end

  assign finished_init        = (state_q == INIT_DONE);
  assign finished_transaction = (state_q == DONE);
  assign rejected             = rejected_q;
  assign p1_balance           = p1_q;
  assign p2_balance           = p2_q;

endmodule

// File: tb/tb_transaction_control.sv
// Directed, table-driven bench for transaction_control with a behavioural
// balance memory (registered read, one write per cycle).
module tb_transaction_control;

  logic       clock = 1'b0;
  logic       resetn;
  logic       init_memory;
  logic       start_transaction;
  logic [7:0] amount;
  logic       key;
  logic [7:0] mem_rdata;
  logic       mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_wren;
  logic       finished_init;
  logic       finished_transaction;
  logic       rejected;
  logic [7:0] p1_balance;
  logic [7:0] p2_balance;

  transaction_control #(.WIDTH(8), .INIT_BALANCE(8'd100)) dut (
    .clock(clock), .resetn(resetn), .init_memory(init_memory),
    .start_transaction(start_transaction), .amount(amount), .key(key),
    .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .finished_init(finished_init),
    .finished_transaction(finished_transaction), .rejected(rejected),
    .p1_balance(p1_balance), .p2_balance(p2_balance)
  );

  always #5 clock = ~clock;

  // Memory model; preloads and write counting share the one process.
  logic [7:0] mem [2];
  logic       load_req = 1'b0;
  logic [7:0] load0 = 8'd0, load1 = 8'd0;
  logic       cnt_clr = 1'b0;
  int         wr_cnt = 0;

  always @(posedge clock) begin
    mem_rdata <= mem[mem_addr];
    if (load_req) begin
      mem[0] <= load0;
      mem[1] <= load1;
    end else if (mem_wren) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (cnt_clr)       wr_cnt <= 0;
    else if (mem_wren) wr_cnt <= wr_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] b0, b1;
    logic       k;
    logic [7:0] amt;
    logic       exp_rej;
    logic [7:0] e0, e1;
    int         lat;
  } vec_t;

  vec_t vecs [8];

  task automatic preload(input logic [7:0] v0, input logic [7:0] v1);
    @(negedge clock);
    load0 = v0; load1 = v1; load_req = 1'b1; cnt_clr = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_init(input logic with_start);
    int lat;
    preload(8'd0, 8'd0);
    @(negedge clock);
    init_memory = 1'b1; start_transaction = with_start;
    lat = 99;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clock); #1;
      if (finished_init) begin lat = n; break; end
    end
    chk("init_latency", lat, 3);
    chk("init_mem0", int'(mem[0]), 100);
    chk("init_mem1", int'(mem[1]), 100);
    chk("init_p1", int'(p1_balance), 100);
    chk("init_p2", int'(p2_balance), 100);
    chk("init_wr_cnt", wr_cnt, 2);
    chk("init_no_xfer", int'(finished_transaction), 0);
    @(posedge clock); #1;
    chk("init_hold", int'(finished_init), 1);
    @(negedge clock);
    init_memory = 1'b0; start_transaction = 1'b0;
    @(posedge clock); #1;
    chk("init_drop", int'(finished_init), 0);
    chk("init_drop_wren", int'(mem_wren), 0);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    int wc;
    string tag;
    tag = $sformatf("v%0d", i);
    preload(v.b0, v.b1);
    @(negedge clock);
    amount = v.amt; key = v.k; start_transaction = 1'b1;
    lat = 99;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clock); #1;
      if (n == 1) begin amount = ~v.amt; key = ~v.k; end
      if (finished_transaction) begin lat = n; break; end
    end
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_rejected"}, int'(rejected), int'(v.exp_rej));
    chk({tag, "_wr_cnt"}, wr_cnt, v.exp_rej ? 0 : 2);
    chk({tag, "_mem0"}, int'(mem[0]), int'(v.e0));
    chk({tag, "_mem1"}, int'(mem[1]), int'(v.e1));
    if (!v.exp_rej) begin
      chk({tag, "_p1"}, int'(p1_balance), int'(v.e0));
      chk({tag, "_p2"}, int'(p2_balance), int'(v.e1));
    end
    wc = wr_cnt;
    @(posedge clock); #1;
    chk({tag, "_hold_done"}, int'(finished_transaction), 1);
    chk({tag, "_hold_no_retrigger"}, wr_cnt, wc);
    @(negedge clock);
    start_transaction = 1'b0;
    @(posedge clock); #1;
    chk({tag, "_release"}, int'(finished_transaction), 0);
  endtask

  initial begin
    vecs[0] = '{8'd100, 8'd100, 1'b0, 8'd30,  1'b0, 8'd70,  8'd130, 7};
    vecs[1] = '{8'd70,  8'd130, 1'b0, 8'd71,  1'b1, 8'd70,  8'd130, 5};
    vecs[2] = '{8'd10,  8'd250, 1'b0, 8'd10,  1'b1, 8'd10,  8'd250, 5};
    vecs[3] = '{8'd10,  8'd250, 1'b0, 8'd5,   1'b0, 8'd5,   8'd255, 7};
    vecs[4] = '{8'd50,  8'd60,  1'b1, 8'd60,  1'b0, 8'd110, 8'd0,   7};
    vecs[5] = '{8'd40,  8'd40,  1'b0, 8'd0,   1'b0, 8'd40,  8'd40,  7};
    vecs[6] = '{8'd0,   8'd0,   1'b1, 8'd1,   1'b1, 8'd0,   8'd0,   5};
    vecs[7] = '{8'd200, 8'd55,  1'b1, 8'd55,  1'b0, 8'd255, 8'd0,   7};

    resetn = 1'b0; init_memory = 1'b0; start_transaction = 1'b0;
    amount = 8'd0; key = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wren", int'(mem_wren), 0);
    chk("rst_fin_init", int'(finished_init), 0);
    chk("rst_fin_xfer", int'(finished_transaction), 0);
    chk("rst_rejected", int'(rejected), 0);
    chk("rst_p1", int'(p1_balance), 0);
    chk("rst_p2", int'(p2_balance), 0);
    @(negedge clock);
    resetn = 1'b1;

    // Init with start also high: init must win.
    do_init(1'b1);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Async reset while in WR_DST, no clock edge before checking.
    preload(8'd100, 8'd100);
    @(negedge clock);
    amount = 8'd30; key = 1'b0; start_transaction = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    chk("wrdst_wren", int'(mem_wren), 1);
    chk("wrdst_addr", int'(mem_addr), 1);
    chk("wrdst_wdata", int'(mem_wdata), 130);
    #1 resetn = 1'b0;
    #1;
    chk("async_wren", int'(mem_wren), 0);
    chk("async_wdata", int'(mem_wdata), 0);
    chk("async_fin_xfer", int'(finished_transaction), 0);
    chk("async_rejected", int'(rejected), 0);
    chk("async_p1", int'(p1_balance), 0);
    chk("async_p2", int'(p2_balance), 0);
    start_transaction = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("post_rst_wren", int'(mem_wren), 0);
    chk("post_rst_fin", int'(finished_transaction), 0);
    chk("partial_mem0", int'(mem[0]), 70);
    chk("partial_mem1", int'(mem[1]), 100);

    do_init(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
